ifetch_ctrl: RTL and testbench

Instruction-fetch bus controller that sequences the IF stage's accesses to the instruction memory over a valid/ready request and response bus. It issues one request per PC, holds the returned instruction while the pipeline stalls, and kills in-flight fetches on any redirect (branch/jump, exception entry, mret). It generates `fetch_hand_suc`, which tells the PC register to advance.

---
 rtl/ifetch_ctrl.sv | 115 +++++++++++
 tb/tb_ifetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: IF-stage instruction bus sequencer (one outstanding valid/ready fetch, stall hold, redirect kill).
// Define IFETCH_TIMEOUT_EN to add the response watchdog and its TIMEOUT_CYC parameter.
module ifetch_ctrl #(
`ifdef IFETCH_TIMEOUT_EN
   parameter int TIMEOUT_CYC = 255,
`endif
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [XLEN-1:0] pc,
   input  logic            pipe_stall,
   input  logic            redirect,
   output logic            ibus_req_valid,
   output logic [XLEN-1:0] ibus_req_addr,
   input  logic            ibus_req_ready,
   input  logic            ibus_rsp_valid,
   input  logic [XLEN-1:0] ibus_rsp_data,
   input  logic            ibus_rsp_err,
   output logic            fetch_hand_suc,
   output logic [XLEN-1:0] if_inst,
   output logic            if_inst_valid,
   output logic            if_bus_err
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t          r_state, w_next, w_after;
   logic [XLEN-1:0] r_hold_inst, w_rsp_inst;
   logic            r_hold_err, r_late, w_rsp_err, w_hold_ld, w_req, w_tmo, w_aligned;

   assign w_aligned     = pc[1:0] == 2'b00;
   assign ibus_req_addr = pc;
   assign ibus_req_valid = w_req;

   always_comb begin
      w_next         = r_state;
      w_after        = if_valid ? S_REQ : S_IDLE;
      w_rsp_err      = ibus_rsp_valid ? ibus_rsp_err : 1'b1;
      w_rsp_inst     = w_rsp_err ? NOP_INST : ibus_rsp_data;
      w_hold_ld      = 1'b0;
      w_req          = 1'b0;
      fetch_hand_suc = 1'b0;
      if_inst_valid  = 1'b0;
      if_bus_err     = 1'b0;
      if_inst        = NOP_INST;
      case (r_state)
         S_IDLE: w_next = (if_valid && w_aligned && !redirect) ? S_REQ : S_IDLE;
         S_REQ: begin
            w_req = !redirect && w_aligned;
            if (w_req && ibus_req_ready) w_next = S_WAIT;
            else if (!if_valid) w_next = S_IDLE;
         end
         S_WAIT: begin
            // a watchdog expiry is treated as a faulted response whose real reply must still be drained
            if (ibus_rsp_valid || w_tmo) begin
               if (redirect) w_next = ibus_rsp_valid ? w_after : S_DROP;
               else if (!pipe_stall) begin
                  if_inst        = w_rsp_inst;
                  if_inst_valid  = 1'b1;
                  if_bus_err     = w_rsp_err;
                  fetch_hand_suc = 1'b1;
                  w_next         = ibus_rsp_valid ? w_after : S_DROP;
               end else begin
                  w_hold_ld = 1'b1;
                  w_next    = S_HOLD;
               end
            end else if (redirect) w_next = S_DROP;
         end
         S_HOLD: begin
            if_inst        = r_hold_inst;
            if_inst_valid  = 1'b1;
            if_bus_err     = r_hold_err;
            fetch_hand_suc = !pipe_stall && !redirect;
            if (redirect || !pipe_stall) w_next = r_late ? S_DROP : w_after;
         end
         S_DROP: if (ibus_rsp_valid || w_tmo) w_next = w_after;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_hold_inst <= NOP_INST;
         r_hold_err  <= 1'b0;
         r_late      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_hold_ld) begin
            r_hold_inst <= w_rsp_inst;
            r_hold_err  <= w_rsp_err;
         end
         r_late <= w_hold_ld ? !ibus_rsp_valid : (r_state == S_HOLD && r_late);
      end
   end

`ifdef IFETCH_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CW-1:0] r_cnt;
   logic          w_cnt_run;

   assign w_cnt_run = r_state == S_WAIT || r_state == S_DROP;
   assign w_tmo     = w_cnt_run && r_cnt == CW'(TIMEOUT_CYC - 1);

   // restarts on every state change so DROP after a WAIT expiry gets its own full window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= (w_cnt_run && w_next == r_state) ? r_cnt + 1'b1 : '0;
   end
`else
   assign w_tmo = 1'b0;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scripted bus scenarios with a scoreboard of expected deliveries for ifetch_ctrl.
module tb_ifetch_ctrl;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        if_valid = 1'b0, pipe_stall = 1'b0, redirect = 1'b0;
   logic        ibus_req_ready = 1'b0, ibus_rsp_valid = 1'b0, ibus_rsp_err = 1'b0;
   logic [31:0] pc = '0, ibus_rsp_data = '0;
   logic        ibus_req_valid, fetch_hand_suc, if_inst_valid, if_bus_err;
   logic [31:0] ibus_req_addr, if_inst;

   int checks = 0, errors = 0;

   typedef struct packed {logic [31:0] inst; logic err;} exp_t;
   exp_t exp_q[$];
   exp_t e;

`ifdef IFETCH_TIMEOUT_EN
   ifetch_ctrl #(.TIMEOUT_CYC(4)) dut (
`else
   ifetch_ctrl dut (
`endif
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .pc(pc), .pipe_stall(pipe_stall),
      .redirect(redirect), .ibus_req_valid(ibus_req_valid), .ibus_req_addr(ibus_req_addr),
      .ibus_req_ready(ibus_req_ready), .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_data(ibus_rsp_data),
      .ibus_rsp_err(ibus_rsp_err), .fetch_hand_suc(fetch_hand_suc), .if_inst(if_inst),
      .if_inst_valid(if_inst_valid), .if_bus_err(if_bus_err)
   );

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      if_valid = 1'b1; ibus_req_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b exp 0", ibus_req_valid); end
      checks++; if ({fetch_hand_suc, if_inst_valid, if_bus_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {fetch_hand_suc, if_inst_valid, if_bus_err}); end
      checks++; if (if_inst !== NOP) begin errors++; $display("FAIL rst_inst: got %h exp %h", if_inst, NOP); end
      if_valid = 1'b0; ibus_req_ready = 1'b0; rst_n = 1'b1;
      cyc;
   endtask

   task automatic test_zero_wait;
      int got, last, first_req;
      logic pend, adv;
      cyc; if_valid = 1'b1; pc = 32'h0; ibus_req_ready = 1'b1; #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL zw_idle: got %b exp 0", ibus_req_valid); end
      pend = 1'b0; adv = 1'b0; got = 0; last = -1; first_req = -1;
      for (int c = 1; c <= 40 && got < 3; c++) begin
         cyc;
         if (adv) pc = pc + 32'd4;
         ibus_rsp_valid = pend; ibus_rsp_data = 32'h0050_0093; ibus_rsp_err = 1'b0;
         if (pend) exp_q.push_back({32'h0050_0093, 1'b0});
         pend = 1'b0;
         #1;
         if (ibus_req_valid && ibus_req_ready) begin
            if (first_req < 0) first_req = c;
            checks++; if (ibus_req_addr !== pc) begin errors++; $display("FAIL zw_addr: got %h exp %h", ibus_req_addr, pc); end
            pend = 1'b1;
         end
         adv = fetch_hand_suc;
         checks++; if (if_inst_valid !== ibus_rsp_valid) begin errors++; $display("FAIL zw_inst_valid: got %b exp %b", if_inst_valid, ibus_rsp_valid); end
         if (fetch_hand_suc) begin
            got++;
            if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL zw_unexpected_pulse: got 1 exp 0"); end
            else begin
               e = exp_q.pop_front();
               checks++; if ({if_inst, if_bus_err} !== {e.inst, e.err}) begin errors++; $display("FAIL zw_data: got %h/%b exp %h/%b", if_inst, if_bus_err, e.inst, e.err); end
            end
            if (last >= 0) begin
               checks++; if (c - last != 2) begin errors++; $display("FAIL zw_rate: got %0d exp 2", c - last); end
            end
            last = c;
         end
      end
      checks++; if (got != 3) begin errors++; $display("FAIL zw_count: got %0d exp 3", got); end
      checks++; if (first_req != 1) begin errors++; $display("FAIL zw_latency: got %0d exp 1", first_req); end
      cyc; if_valid = 1'b0; ibus_req_ready = 1'b0; ibus_rsp_valid = 1'b0; pc = pc + 32'd4;
      cyc; #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL zw_end_idle: got %b exp 0", ibus_req_valid); end
   endtask

   task automatic test_stall_hold;
      cyc; if_valid = 1'b1; pc = 32'h20; ibus_req_ready = 1'b1;
      cyc; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr} !== {1'b1, 32'h20}) begin errors++; $display("FAIL st_req: got %b/%h exp 1/20", ibus_req_valid, ibus_req_addr); end
      cyc; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'h00A0_0113; pipe_stall = 1'b1;
      exp_q.push_back({32'h00A0_0113, 1'b0});
      #1;
      checks++; if (fetch_hand_suc !== 1'b0) begin errors++; $display("FAIL st_rsp_pulse: got %b exp 0", fetch_hand_suc); end
      for (int i = 0; i < 2; i++) begin
         cyc; ibus_rsp_valid = 1'b0; ibus_rsp_data = 32'hFFFF_FFFF; #1;
         checks++; if ({if_inst, if_inst_valid, fetch_hand_suc} !== {32'h00A0_0113, 2'b10}) begin errors++; $display("FAIL st_hold: got %h/%b/%b exp 00a00113/1/0", if_inst, if_inst_valid, fetch_hand_suc); end
      end
      cyc; pipe_stall = 1'b0; #1;
      checks++; if (fetch_hand_suc !== 1'b1) begin errors++; $display("FAIL st_release_pulse: got %b exp 1", fetch_hand_suc); end
      if (fetch_hand_suc && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++; if ({if_inst, if_bus_err, if_inst_valid} !== {e.inst, e.err, 1'b1}) begin errors++; $display("FAIL st_data: got %h/%b/%b exp %h/%b/1", if_inst, if_bus_err, if_inst_valid, e.inst, e.err); end
      end
      cyc; pc = 32'h24; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr} !== {1'b1, 32'h24}) begin errors++; $display("FAIL st_next_req: got %b/%h exp 1/24", ibus_req_valid, ibus_req_addr); end
      if_valid = 1'b0; ibus_req_ready = 1'b0;
      cyc;
   endtask

   task automatic test_hold_redirect;
      cyc; if_valid = 1'b1; pc = 32'h30; ibus_req_ready = 1'b1;
      cyc;
      cyc; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'h0011_2233; pipe_stall = 1'b1;
      cyc; ibus_rsp_valid = 1'b0; redirect = 1'b1; #1;
      checks++; if ({fetch_hand_suc, if_inst_valid} !== 2'b01) begin errors++; $display("FAIL hr_pulse: got %b/%b exp 0/1", fetch_hand_suc, if_inst_valid); end
      cyc; redirect = 1'b0; pipe_stall = 1'b0; pc = 32'h180; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr, fetch_hand_suc} !== {1'b1, 32'h180, 1'b0}) begin errors++; $display("FAIL hr_req: got %b/%h/%b exp 1/180/0", ibus_req_valid, ibus_req_addr, fetch_hand_suc); end
      if_valid = 1'b0; ibus_req_ready = 1'b0;
      cyc;
   endtask

   task automatic test_redirect_wait;
      cyc; if_valid = 1'b1; pc = 32'h10; ibus_req_ready = 1'b1;
      cyc;
      cyc; redirect = 1'b1; #1;
      checks++; if (fetch_hand_suc !== 1'b0) begin errors++; $display("FAIL rw_pulse_redir: got %b exp 0", fetch_hand_suc); end
      cyc; redirect = 1'b0; pc = 32'h80; #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_noreq: got %b exp 0", ibus_req_valid); end
      cyc; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'hDEAD_BEEF; #1;
      checks++; if ({fetch_hand_suc, if_inst_valid, if_inst} !== {2'b00, NOP}) begin errors++; $display("FAIL rw_discard: got %b/%b/%h exp 0/0/%h", fetch_hand_suc, if_inst_valid, if_inst, NOP); end
      cyc; ibus_rsp_valid = 1'b0; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL rw_new_req: got %b/%h exp 1/80", ibus_req_valid, ibus_req_addr); end
      if_valid = 1'b0; ibus_req_ready = 1'b0;
      cyc;
   endtask

   task automatic test_redirect_coincident;
      cyc; if_valid = 1'b1; pc = 32'h40; ibus_req_ready = 1'b1;
      cyc;
      cyc; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'h1234_5678; redirect = 1'b1; #1;
      checks++; if ({fetch_hand_suc, if_inst_valid, if_inst} !== {2'b00, NOP}) begin errors++; $display("FAIL rc_discard: got %b/%b/%h exp 0/0/%h", fetch_hand_suc, if_inst_valid, if_inst, NOP); end
      cyc; ibus_rsp_valid = 1'b0; redirect = 1'b0; pc = 32'h100; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rc_new_req: got %b/%h exp 1/100", ibus_req_valid, ibus_req_addr); end
      if_valid = 1'b0; ibus_req_ready = 1'b0;
      cyc;
   endtask

   task automatic test_bus_err;
      cyc; if_valid = 1'b1; pc = 32'h60; ibus_req_ready = 1'b1;
      cyc;
      cyc; ibus_rsp_valid = 1'b1; ibus_rsp_err = 1'b1; ibus_rsp_data = 32'hFFFF_FFFF; if_valid = 1'b0;
      exp_q.push_back({NOP, 1'b1});
      #1;
      checks++; if (fetch_hand_suc !== 1'b1) begin errors++; $display("FAIL be_pulse: got %b exp 1", fetch_hand_suc); end
      if (fetch_hand_suc && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++; if ({if_inst, if_bus_err, if_inst_valid} !== {e.inst, e.err, 1'b1}) begin errors++; $display("FAIL be_data: got %h/%b/%b exp %h/%b/1", if_inst, if_bus_err, if_inst_valid, e.inst, e.err); end
      end
      cyc; ibus_rsp_valid = 1'b0; ibus_rsp_err = 1'b0; ibus_req_ready = 1'b0; #1;
      checks++; if ({fetch_hand_suc, if_bus_err, ibus_req_valid} !== 3'b000) begin errors++; $display("FAIL be_after: got %b exp 000", {fetch_hand_suc, if_bus_err, ibus_req_valid}); end
   endtask

   task automatic test_redirect_req_misaligned;
      cyc; if_valid = 1'b1; pc = 32'h2; ibus_req_ready = 1'b1;
      cyc; #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL ma_noreq: got %b exp 0", ibus_req_valid); end
      pc = 32'hE0;
      cyc; redirect = 1'b1; #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL rq_redir_noreq: got %b exp 0", ibus_req_valid); end
      cyc; redirect = 1'b0; pc = 32'h200; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL rq_new_req: got %b/%h exp 1/200", ibus_req_valid, ibus_req_addr); end
      if_valid = 1'b0; ibus_req_ready = 1'b0;
      cyc;
   endtask

   task automatic test_reset_mid;
      cyc; if_valid = 1'b1; pc = 32'hC0; ibus_req_ready = 1'b1;
      cyc;
      cyc; rst_n = 1'b0; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'h0000_0093; #1;
      checks++; if ({fetch_hand_suc, if_inst_valid} !== 2'b00) begin errors++; $display("FAIL rm_pulse: got %b exp 00", {fetch_hand_suc, if_inst_valid}); end
      cyc; ibus_rsp_valid = 1'b0; if_valid = 1'b0; rst_n = 1'b1;
      cyc; #1;
      checks++; if (ibus_req_valid !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b exp 0", ibus_req_valid); end
      ibus_req_ready = 1'b0;
   endtask

`ifdef IFETCH_TIMEOUT_EN
   task automatic test_timeout;
      cyc; if_valid = 1'b1; pc = 32'hA0; ibus_req_ready = 1'b1;
      cyc;
      for (int w = 1; w <= 3; w++) begin
         cyc; #1;
         checks++; if (fetch_hand_suc !== 1'b0) begin errors++; $display("FAIL to_early: got %b exp 0 wait %0d", fetch_hand_suc, w); end
      end
      cyc; exp_q.push_back({NOP, 1'b1}); #1;
      checks++; if (fetch_hand_suc !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b exp 1", fetch_hand_suc); end
      if (fetch_hand_suc && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++; if ({if_inst, if_bus_err} !== {e.inst, e.err}) begin errors++; $display("FAIL to_data: got %h/%b exp %h/%b", if_inst, if_bus_err, e.inst, e.err); end
      end
      for (int d = 0; d < 3; d++) begin
         cyc; pc = 32'hA4; ibus_rsp_valid = (d == 2); ibus_rsp_data = 32'h0050_0093; #1;
         checks++; if ({ibus_req_valid, fetch_hand_suc} !== 2'b00) begin errors++; $display("FAIL to_drop: got %b exp 00 cycle %0d", {ibus_req_valid, fetch_hand_suc}, d); end
      end
      cyc; ibus_rsp_valid = 1'b0; #1;
      checks++; if ({ibus_req_valid, ibus_req_addr} !== {1'b1, 32'hA4}) begin errors++; $display("FAIL to_next_req: got %b/%h exp 1/a4", ibus_req_valid, ibus_req_addr); end
      if_valid = 1'b0; ibus_req_ready = 1'b0;
      cyc;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_zero_wait;
      test_stall_hold;
      test_hold_redirect;
      test_redirect_wait;
      test_redirect_coincident;
      test_bus_err;
      test_redirect_req_misaligned;
      test_reset_mid;
`ifdef IFETCH_TIMEOUT_EN
      test_timeout;
`endif
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending exp 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
